// File: rtl/if_id_buf.sv
// if_id_buf: show-ahead fetch FIFO between PC and decode; a push is visible at the head one cycle later.
// Full pushes are dropped (sticky ovf_o only with IF_ID_BUF_OVF_EN); stall_req_o asserts at DEPTH-1.
module if_id_buf #(
  parameter int ADDR_W = 6,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              ce_i,
  input  logic [INST_W-1:0] inst_i,
  input  logic              flush_i,
  input  logic              id_ready_i,
  output logic              id_valid_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic              stall_req_o,
  output logic              ovf_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ALMOST = CNT_W'(DEPTH - 1);

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic empty;
  logic full;
  logic pop;
  logic push;

  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);

  // Pop depends only on stored state, so an entry pushed into an empty buffer cannot leave on the same edge.
  assign pop  = !empty && id_ready_i && !flush_i;
  assign push = ce_i && !flush_i && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
    end
  end

  // Storage is left unreset; the outputs are masked whenever count is zero.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      pc_mem[wr_ptr]   <= pc_i;
      inst_mem[wr_ptr] <= inst_i;
    end
  end

  assign id_valid_o  = !empty;
  assign id_pc_o     = empty ? '0 : pc_mem[rd_ptr];
  assign id_inst_o   = empty ? '0 : inst_mem[rd_ptr];
  assign stall_req_o = (count >= CNT_ALMOST);

`ifdef IF_ID_BUF_OVF_EN
  logic ovf;
  logic drop;

  assign drop = ce_i && !flush_i && full && !pop;

  // Sticky until reset; flush deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end
  end

  assign ovf_o = ovf;
`else
  assign ovf_o = 1'b0;
`endif

endmodule

// File: tb/tb_if_id_buf.sv
// Bench for if_id_buf: queue-based reference model checked every cycle plus directed literal checks.
module tb_if_id_buf;

  localparam int AW = 6;
  localparam int IW = 32;
  localparam int D  = 4;

`ifdef IF_ID_BUF_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [AW-1:0] pc_i;
  logic          ce_i;
  logic [IW-1:0] inst_i;
  logic          flush_i;
  logic          id_ready_i;
  logic          id_valid_o;
  logic [AW-1:0] id_pc_o;
  logic [IW-1:0] id_inst_o;
  logic          stall_req_o;
  logic          ovf_o;

  if_id_buf #(.ADDR_W(AW), .INST_W(IW), .DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_i       (pc_i),
    .ce_i       (ce_i),
    .inst_i     (inst_i),
    .flush_i    (flush_i),
    .id_ready_i (id_ready_i),
    .id_valid_o (id_valid_o),
    .id_pc_o    (id_pc_o),
    .id_inst_o  (id_inst_o),
    .stall_req_o(stall_req_o),
    .ovf_o      (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of fetches with a capacity limit.
  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] inst;
  } ent_t;

  ent_t q[$];
  bit   m_ovf = 1'b0;
  bit   live  = 1'b0;

  function automatic void model_step();
    bit   will_pop;
    bit   will_push;
    ent_t e;
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
      live  = 1'b1;
      return;
    end
    if (flush_i) begin
      q.delete();
      return;
    end
    will_pop  = (q.size() != 0) && id_ready_i;
    will_push = ce_i && ((q.size() < D) || will_pop);
    if (ce_i && !will_push) m_ovf = 1'b1;
    if (will_pop) void'(q.pop_front());
    if (will_push) begin
      e.pc   = pc_i;
      e.inst = inst_i;
      q.push_back(e);
    end
  endfunction

  always @(posedge clk) model_step();

  logic [AW-1:0] e_pc;
  logic [IW-1:0] e_inst;

  always @(negedge clk) begin
    if (live) begin
      if (q.size() != 0) begin
        e_pc   = q[0].pc;
        e_inst = q[0].inst;
      end else begin
        e_pc   = '0;
        e_inst = '0;
      end
      chk("cmp_valid", 64'(id_valid_o), 64'(q.size() != 0));
      chk("cmp_pc", 64'(id_pc_o), 64'(e_pc));
      chk("cmp_inst", 64'(id_inst_o), 64'(e_inst));
      chk("cmp_stall", 64'(stall_req_o), 64'(q.size() >= D - 1));
      chk("cmp_ovf", 64'(ovf_o), 64'(OVF_ON ? m_ovf : 1'b0));
    end
  end

  task automatic drive(input logic c, input logic [AW-1:0] p, input logic [IW-1:0] in,
                       input logic r, input logic f);
    ce_i       = c;
    pc_i       = p;
    inst_i     = in;
    id_ready_i = r;
    flush_i    = f;
  endtask

  // One rising edge, then settle just after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_valid", 64'(id_valid_o), 64'd0);
    chk("rst_pc", 64'(id_pc_o), 64'd0);
    chk("rst_inst", 64'(id_inst_o), 64'd0);
    chk("rst_stall", 64'(stall_req_o), 64'd0);
    chk("rst_ovf", 64'(ovf_o), 64'd0);

    // Basic flow with decode always ready.
    drive(1'b1, 6'd0, 32'hA0, 1'b1, 1'b0);
    chk("basic_pre_valid", 64'(id_valid_o), 64'd0);
    cyc();
    chk("basic_h0_valid", 64'(id_valid_o), 64'd1);
    chk("basic_h0_pc", 64'(id_pc_o), 64'd0);
    chk("basic_h0_inst", 64'(id_inst_o), 64'hA0);
    drive(1'b1, 6'd1, 32'hA1, 1'b1, 1'b0);
    cyc();
    chk("basic_h1_pc", 64'(id_pc_o), 64'd1);
    chk("basic_h1_inst", 64'(id_inst_o), 64'hA1);
    drive(1'b1, 6'd2, 32'hA2, 1'b1, 1'b0);
    cyc();
    chk("basic_h2_pc", 64'(id_pc_o), 64'd2);
    chk("basic_h2_inst", 64'(id_inst_o), 64'hA2);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    cyc();
    chk("basic_drained", 64'(id_valid_o), 64'd0);
    cyc();
    chk("empty_ready_noop", 64'(id_valid_o), 64'd0);

    // Fill and overflow with decode stalled.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, AW'(i), 32'hB0 + 32'(i), 1'b0, 1'b0);
      cyc();
      chk("fill_stall", 64'(stall_req_o), 64'(i >= 2));
    end
    chk("fill_head_pc", 64'(id_pc_o), 64'd0);
    chk("fill_head_inst", 64'(id_inst_o), 64'hB0);
    chk("fill_ovf", 64'(ovf_o), 64'(OVF_ON));

    // Full buffer with simultaneous push and pop.
    drive(1'b1, 6'd9, 32'hC9, 1'b1, 1'b0);
    cyc();
    chk("fullpp_head", 64'(id_pc_o), 64'd1);
    chk("fullpp_stall", 64'(stall_req_o), 64'd1);
    chk("fullpp_ovf", 64'(ovf_o), 64'(OVF_ON));
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    cyc();
    chk("fullpp_h2", 64'(id_pc_o), 64'd2);
    cyc();
    chk("fullpp_h3", 64'(id_pc_o), 64'd3);
    cyc();
    chk("fullpp_h9_pc", 64'(id_pc_o), 64'd9);
    chk("fullpp_h9_inst", 64'(id_inst_o), 64'hC9);
    cyc();
    chk("fullpp_empty", 64'(id_valid_o), 64'd0);

    // Flush beats a same-cycle push and pop.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, AW'(16 + i), 32'hE0 + 32'(i), 1'b0, 1'b0);
      cyc();
    end
    drive(1'b1, 6'h13, 32'hE3, 1'b1, 1'b1);
    cyc();
    chk("flush_valid", 64'(id_valid_o), 64'd0);
    chk("flush_pc", 64'(id_pc_o), 64'd0);
    chk("flush_stall", 64'(stall_req_o), 64'd0);
    chk("flush_ovf_kept", 64'(ovf_o), 64'(OVF_ON));
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    cyc();
    chk("flush_not_stored", 64'(id_valid_o), 64'd0);

    // Pointer wrap: streaming push/pop well past DEPTH.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, AW'(i), 32'h100 + 32'(i), 1'b1, 1'b0);
      cyc();
      chk("wrap_head", 64'(id_pc_o), 64'(i));
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    cyc();
    chk("wrap_empty", 64'(id_valid_o), 64'd0);

    // Reset mid-stream with a full, overflowed buffer.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, AW'(32 + i), 32'h200 + 32'(i), 1'b0, 1'b0);
      cyc();
    end
    chk("prerst_ovf", 64'(ovf_o), 64'(OVF_ON));
    rst = 1'b1;
    drive(1'b1, 6'h3F, 32'hFFFF, 1'b1, 1'b1);
    cyc();
    rst = 1'b0;
    chk("midrst_valid", 64'(id_valid_o), 64'd0);
    chk("midrst_pc", 64'(id_pc_o), 64'd0);
    chk("midrst_inst", 64'(id_inst_o), 64'd0);
    chk("midrst_stall", 64'(stall_req_o), 64'd0);
    chk("midrst_ovf", 64'(ovf_o), 64'd0);
    drive(1'b1, 6'h2A, 32'hDEAD, 1'b0, 1'b0);
    cyc();
    chk("postrst_pc", 64'(id_pc_o), 64'h2A);
    chk("postrst_inst", 64'(id_inst_o), 64'hDEAD);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
